// File: rtl/softplus_pkg.sv
// Shared constants and stage bundle for the SoftPlus piecewise-linear evaluator.
package softplus_pkg;

    localparam int DATA_W      = 16;
    localparam int GRAD_FRAC   = 7;
    localparam int PIPE_STAGES = 3;

    // Q8.8 saturation limits
    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [DATA_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/grad_softplus.sv
// Segment lookup for the piecewise-linear SoftPlus: maps a Q8.8 operand to an
// unsigned gradient code (Q1.7 scale) and an unsigned Q8.8 offset.
//   x <  -4.0        : grad   0, offset   0
//   -4.0 <= x < -1.0 : grad   3, offset  55
//   -1.0 <= x <  1.0 : grad  64, offset  77
//    1.0 <= x <  4.0 : grad  90, offset  55
//    4.0 <= x        : grad 110, offset   3
module grad_softplus
    import softplus_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    output logic [15:0]       grad,
    output logic [15:0]       offset
);

    localparam logic signed [DATA_W-1:0] BP_NEG4 = -16'sd1024;
    localparam logic signed [DATA_W-1:0] BP_NEG1 = -16'sd256;
    localparam logic signed [DATA_W-1:0] BP_POS1 = 16'sd256;
    localparam logic signed [DATA_W-1:0] BP_POS4 = 16'sd1024;

    logic signed [DATA_W-1:0] xs;
    assign xs = signed'(x);

    // Breakpoint compare against the signed operand selects the segment.
    always_comb begin
        grad   = 16'd0;
        offset = 16'd0;
        if (xs < BP_NEG4) begin
            grad   = 16'd0;
            offset = 16'd0;
        end else if (xs < BP_NEG1) begin
            grad   = 16'd3;
            offset = 16'd55;
        end else if (xs < BP_POS1) begin
            grad   = 16'd64;
            offset = 16'd77;
        end else if (xs < BP_POS4) begin
            grad   = 16'd90;
            offset = 16'd55;
        end else begin
            grad   = 16'd110;
            offset = 16'd3;
        end
    end

endmodule

// File: rtl/softplus_pwl_eval.sv
// Three-stage valid/ready evaluator: y = ((grad * x) >>> GRAD_FRAC) + offset,
// saturated to Q8.8. All stages advance together on a single enable, so a
// stalled output freezes the whole pipe and bubbles are kept in place.
// Optional performance counters are compiled in with SOFTPLUS_PERF_EN.
module softplus_pwl_eval
    import softplus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
`ifdef SOFTPLUS_PERF_EN
    ,
    output logic [15:0]       elem_cnt,
    output logic [15:0]       vec_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic signed [32:0] SUM_MAX = 33'(signed'(SAT_MAX));
    localparam logic signed [32:0] SUM_MIN = 33'(signed'(SAT_MIN));

    stage_t             s1_q;
    stage_t             s3_q;
    logic               s2_valid_q;
    logic               s2_last_q;
    logic signed [31:0] s2_prod_q;
    logic [15:0]        s2_off_q;

    logic               en;
    logic [15:0]        grad_c;
    logic [15:0]        off_c;
    logic signed [31:0] grad_ext;
    logic signed [31:0] x_ext;
    logic signed [31:0] prod_c;
    logic signed [31:0] shr_c;
    logic signed [32:0] sum_c;
    logic [DATA_W-1:0]  sat_c;

    assign en        = !s3_q.valid || out_ready;
    assign in_ready  = en;
    assign out_valid = s3_q.valid;
    assign out_data  = s3_q.data;
    assign out_last  = s3_q.last;
    assign busy      = s1_q.valid | s2_valid_q | s3_q.valid;

    grad_softplus u_grad (
        .x      (s1_q.data),
        .grad   (grad_c),
        .offset (off_c)
    );

    // Gradient is an unsigned code, so it is zero-extended before the signed multiply.
    assign grad_ext = signed'({16'b0, grad_c});
    assign x_ext    = signed'({{(32-DATA_W){s1_q.data[DATA_W-1]}}, s1_q.data});
    assign prod_c   = grad_ext * x_ext;

    // Shift floors toward minus infinity; sum kept at 33 bits so the clamp sees true overflow.
    always_comb begin
        shr_c = s2_prod_q >>> GRAD_FRAC;
        sum_c = {shr_c[31], shr_c} + {17'b0, s2_off_q};
        sat_c = sum_c[DATA_W-1:0];
        if (sum_c > SUM_MAX) begin
            sat_c = SAT_MAX;
        end else if (sum_c < SUM_MIN) begin
            sat_c = SAT_MIN;
        end
    end

    // Pipeline registers: every stage shifts on en and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s2_off_q   <= '0;
            s3_q       <= '0;
        end else if (en) begin
            s1_q       <= '{valid: in_valid, last: in_last, data: in_data};
            s2_valid_q <= s1_q.valid;
            s2_last_q  <= s1_q.last;
            s2_prod_q  <= prod_c;
            s2_off_q   <= off_c;
            s3_q       <= '{valid: s2_valid_q, last: s2_last_q, data: sat_c};
        end
    end

`ifdef SOFTPLUS_PERF_EN
    logic out_xfer;
    assign out_xfer = s3_q.valid && out_ready;

    // Element/vector counts follow output transfers; stall count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt  <= '0;
            vec_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_xfer) begin
                if (s3_q.last) begin
                    elem_cnt <= '0;
                    vec_cnt  <= vec_cnt + 16'd1;
                end else begin
                    elem_cnt <= elem_cnt + 16'd1;
                end
            end
            if (s3_q.valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_softplus_pwl_eval.sv
// Scoreboard bench for softplus_pwl_eval. Define SOFTPLUS_PERF_EN to also
// exercise the performance counters.
module tb_softplus_pwl_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
`ifdef SOFTPLUS_PERF_EN
    logic [15:0] elem_cnt;
    logic [15:0] vec_cnt;
    logic [31:0] stall_cnt;
`endif

    softplus_pwl_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SOFTPLUS_PERF_EN
        ,
        .elem_cnt  (elem_cnt),
        .vec_cnt   (vec_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t sq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: SoftPlus segments in real units (breakpoints -4, -1, 1, 4),
    // slope expressed in 1/128 steps, result floored and clamped to Q8.8.
    function automatic logic [15:0] ref_y(input logic [15:0] xin);
        int     x;
        int     g;
        int     o;
        longint p;
        longint q;
        longint y;
        x = int'(signed'(xin));
        if (x < -4 * 256)      begin g = 0;   o = 0;  end
        else if (x < -1 * 256) begin g = 3;   o = 55; end
        else if (x < 1 * 256)  begin g = 64;  o = 77; end
        else if (x < 4 * 256)  begin g = 90;  o = 55; end
        else                   begin g = 110; o = 3;  end
        p = longint'(g) * longint'(x);
        if (p >= 0) q = p / 128;
        else        q = -((-p + 127) / 128);
        y = q + longint'(o);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return 16'(y);
    endfunction

    // Drive one cycle of stimulus; record the expected result if the beat is accepted.
    task automatic cyc(input logic v, input logic [15:0] d, input logic l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #2;
        if (v && in_ready && !rst) sq.push_back(exp_t'{data: ref_y(d), last: l});
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sq.size() != 0 && k < 200) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            k++;
        end
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        #1;
        check("drain_empty", 32'(sq.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sq.delete();
    endtask

    // Monitor: pops on each output transfer, checks hold behaviour during stalls.
    logic        stall_prev = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst !== 1'b0) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
                end else begin
                    e = sq.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int run;
        int best;
        logic v;
        logic r;
        logic [15:0] d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Single beat latency and value
        cyc(1'b1, 16'h0000, 1'b1, 1'b1);
        lat = 1;
        while (lat < 20) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            #1;
            if (out_valid) break;
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("zero_value", 32'(out_data), 32'h004D);
        check("zero_last", 32'(out_last), 32'd1);
        drain();

        // Back-to-back stream, then count consecutive output cycles
        cyc(1'b1, 16'h0000, 1'b0, 1'b1);
        cyc(1'b1, 16'h0180, 1'b0, 1'b1);
        cyc(1'b1, 16'hFE80, 1'b0, 1'b1);
        cyc(1'b1, 16'h8000, 1'b1, 1'b1);
        run  = 0;
        best = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            #1;
            if (out_valid) run++;
            else run = 0;
            if (run > best) best = run;
        end
        check("stream_run", 32'(best), 32'd3);
        drain();

        // Backpressure: stall for five cycles while outputs are pending
        cyc(1'b1, 16'h0000, 1'b0, 1'b1);
        cyc(1'b1, 16'h0180, 1'b0, 1'b1);
        cyc(1'b1, 16'hFE80, 1'b0, 1'b1);
        cyc(1'b1, 16'h8000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'h0200, 1'b0, 1'b0);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        drain();

        // Reset with beats in flight
        cyc(1'b1, 16'h0180, 1'b0, 1'b1);
        cyc(1'b1, 16'hFE80, 1'b0, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sq.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        cyc(1'b1, 16'h7FFF, 1'b0, 1'b1);
        lat = 1;
        while (lat < 20) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            #1;
            if (out_valid) break;
            lat++;
        end
        check("post_rst_latency", 32'(lat), 32'd3);
        check("max_value", 32'(out_data), 32'h6E02);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            v = ($urandom % 10) < 7;
            r = ($urandom % 10) < 7;
            case ($urandom % 4)
                0:       d = 16'($urandom);
                1:       d = 16'($urandom_range(0, 2400)) - 16'd1200;
                2:       d = 16'h8000 + 16'($urandom_range(0, 8));
                default: d = 16'h7FFF - 16'($urandom_range(0, 8));
            endcase
            cyc(v, d, ($urandom % 4) == 0, r);
        end
        drain();

`ifdef SOFTPLUS_PERF_EN
        do_reset();
        cyc(1'b1, 16'h0100, 1'b0, 1'b1);
        cyc(1'b1, 16'h0200, 1'b0, 1'b1);
        cyc(1'b1, 16'h0300, 1'b1, 1'b1);
        cyc(1'b1, 16'hFF00, 1'b0, 1'b1);
        cyc(1'b1, 16'hFE00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
        drain();
        check("perf_vec_cnt", 32'(vec_cnt), 32'd2);
        check("perf_elem_cnt", 32'(elem_cnt), 32'd0);
        check("perf_stall_cnt", stall_cnt, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
